// File: rtl/disp_page_sched_pkg.sv
// Shared definitions for the display page scheduler: page count, default timing, FSM states.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package disp_page_sched_pkg;

    localparam int NPAGE            = 4;
    localparam int AUTO_CYCLES_DEF  = 100_000_000;  // 2 s per page at 50 MHz
    localparam int INDEX_CYCLES_DEF = 25_000_000;   // 0.5 s page-number screen

    typedef enum logic {
        SHOW  = 1'b0,   // page data on the display
        INDEX = 1'b1    // page number on the display
    } state_t;

    // Active-low decimal point marking the current page position.
    function automatic logic [3:0] dp_for(input logic [1:0] page);
        return ~(4'b0001 << page);
    endfunction

endpackage

// File: rtl/disp_page_sched_cycle_timer.sv
// Free-running cycle counter with clear, enable and terminal-count compare against a runtime limit.
// Latency: count is registered; tc is combinational from count and limit.
// Backpressure: none; clear has priority over enable.
//
// Ports: clk, reset (sync, active-high), clr, en, limit[TW], count[TW], tc.
module disp_page_sched_cycle_timer #(
    parameter int TW = 27
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    input  logic [TW-1:0] limit,
    output logic [TW-1:0] count,
    output logic          tc
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + TW'(1);
        end
    end

    assign tc = (count == limit);

endmodule

// File: rtl/disp_page_sched.sv
// Shares one 4-digit hex display between four 16-bit pages; manual or auto-rotating page select.
// Latency: one cycle from pages_in / ticks to all outputs (everything registered).
// Backpressure: none; ticks are consumed one per asserted cycle.
//
// Ports: clk, reset (sync, active-high), next_tick, mode_tick, pages_in[64] (page p at [16p+:16]),
//        hex3..hex0 (digit nibbles), dp_in (active-low decimal points), page_idx, auto_mode.
module disp_page_sched
    import disp_page_sched_pkg::*;
#(
    parameter int AUTO_CYCLES  = AUTO_CYCLES_DEF,
    parameter int INDEX_CYCLES = INDEX_CYCLES_DEF,
    parameter int TW           = 27
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        next_tick,
    input  logic        mode_tick,
    input  logic [63:0] pages_in,
    output logic [3:0]  hex3,
    output logic [3:0]  hex2,
    output logic [3:0]  hex1,
    output logic [3:0]  hex0,
    output logic [3:0]  dp_in,
    output logic [1:0]  page_idx,
    output logic        auto_mode
);

    logic [NPAGE-1:0][15:0] pages;
    assign pages = pages_in;

    state_t        state, state_n;
    logic [1:0]    page_n;
    logic          auto_n;
    logic [15:0]   hex_q, hex_n;
    logic [3:0]    dp_n;

    logic [TW-1:0] tmr_limit;
    logic [TW-1:0] tmr_count;
    logic          tmr_tc;
    logic          tmr_clr;
    logic          tmr_en;
    logic          adv;

    // One timer serves both phases; its terminal count means "rotate" in SHOW
    // and "hold finished" in INDEX.
    assign tmr_limit = (state == SHOW) ? TW'(AUTO_CYCLES - 1) : TW'(INDEX_CYCLES - 1);

    // A manual tick and an auto expiry in the same cycle collapse into one advance.
    assign adv = next_tick | (auto_mode & (state == SHOW) & tmr_tc);

    disp_page_sched_cycle_timer #(
        .TW (TW)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .limit (tmr_limit),
        .count (tmr_count),
        .tc    (tmr_tc)
    );

    always_comb begin
        state_n = state;
        page_n  = page_idx;
        auto_n  = auto_mode ^ mode_tick;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;

        if (adv) begin
            page_n  = page_idx + 2'd1;
            state_n = INDEX;
            tmr_clr = 1'b1;
        end else if (state == INDEX) begin
            // mode_tick deliberately has no effect on the INDEX hold.
            if (tmr_tc) begin
                state_n = SHOW;
                tmr_clr = 1'b1;
            end else begin
                tmr_en = 1'b1;
            end
        end else begin
            // SHOW: count only while rotating; a mode change restarts the period.
            if (mode_tick || !auto_mode) begin
                tmr_clr = 1'b1;
            end else begin
                tmr_en = 1'b1;
            end
        end

        // Outputs are computed from the next state so they change in the same
        // cycle as page_idx; page data is re-sampled every cycle in SHOW.
        hex_n = (state_n == INDEX) ? {14'd0, page_n} : pages[page_n];
        dp_n  = dp_for(page_n);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SHOW;
            page_idx  <= 2'd0;
            auto_mode <= 1'b0;
            hex_q     <= 16'h0000;
            dp_in     <= 4'b1110;
        end else begin
            state     <= state_n;
            page_idx  <= page_n;
            auto_mode <= auto_n;
            hex_q     <= hex_n;
            dp_in     <= dp_n;
        end
    end

    assign hex3 = hex_q[15:12];
    assign hex2 = hex_q[11:8];
    assign hex1 = hex_q[7:4];
    assign hex0 = hex_q[3:0];

endmodule

// File: tb/tb_disp_page_sched.sv
// Self-checking bench for disp_page_sched with small timing parameters.
// Latency: n/a.
// Backpressure: n/a.
module tb_disp_page_sched;

    localparam int AC = 10;
    localparam int IC = 3;
    localparam logic [63:0] PAGES_DEF = {16'hBEEF, 16'h00FF, 16'hABCD, 16'h1234};

    logic        clk;
    logic        reset;
    logic        next_tick;
    logic        mode_tick;
    logic [63:0] pages_in;
    logic [3:0]  hex3, hex2, hex1, hex0;
    logic [3:0]  dp_in;
    logic [1:0]  page_idx;
    logic        auto_mode;

    int vecs = 0;
    int errs = 0;

    // Reference model: which page, whether the page-number screen is up,
    // and how many cycles the current phase has lasted.
    int          m_page;
    bit          m_auto;
    bit          m_idx;
    int          m_age;
    logic [15:0] m_hex;

    disp_page_sched #(
        .AUTO_CYCLES  (AC),
        .INDEX_CYCLES (IC),
        .TW           (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .next_tick (next_tick),
        .mode_tick (mode_tick),
        .pages_in  (pages_in),
        .hex3      (hex3),
        .hex2      (hex2),
        .hex1      (hex1),
        .hex0      (hex0),
        .dp_in     (dp_in),
        .page_idx  (page_idx),
        .auto_mode (auto_mode)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [22:0] obs();
        return {hex3, hex2, hex1, hex0, dp_in, page_idx, auto_mode};
    endfunction

    function automatic logic [22:0] expv();
        logic [3:0] dp;
        dp = ~(4'b0001 << m_page);
        return {m_hex, dp, 2'(m_page), m_auto};
    endfunction

    // Apply one cycle of inputs, advance the model at the same edge, settle.
    task automatic step(input bit nt, input bit mt, input bit rst);
        bit adv;
        next_tick = nt;
        mode_tick = mt;
        reset     = rst;
        @(posedge clk);
        if (rst) begin
            m_page = 0; m_auto = 0; m_idx = 0; m_age = 0; m_hex = 16'h0000;
        end else begin
            adv = nt || (m_auto && !m_idx && m_age == AC - 1);
            if (adv) begin
                m_page = (m_page + 1) % 4;
                m_idx  = 1;
                m_age  = 0;
            end else if (m_idx) begin
                if (m_age == IC - 1) begin
                    m_idx = 0;
                    m_age = 0;
                end else begin
                    m_age++;
                end
            end else if (mt || !m_auto) begin
                m_age = 0;
            end else begin
                m_age++;
            end
            if (mt) m_auto = !m_auto;
            m_hex = m_idx ? 16'(m_page) : pages_in[16*m_page +: 16];
        end
        #1;
        next_tick = 1'b0;
        mode_tick = 1'b0;
        reset     = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 1);
            vecs++;
            if (obs() !== {16'h0000, 4'b1110, 2'd0, 1'b0}) begin
                errs++;
                $display("FAIL reset_hold: got %h want %h", obs(), {16'h0000, 4'b1110, 2'd0, 1'b0});
            end
        end
        step(0, 0, 0);
        vecs++;
        if (obs() !== {16'h1234, 4'b1110, 2'd0, 1'b0}) begin
            errs++;
            $display("FAIL reset_release: got %h want %h", obs(), {16'h1234, 4'b1110, 2'd0, 1'b0});
        end
        for (int i = 0; i < 50; i++) begin
            step(0, 0, 0);
            vecs++;
            if (obs() !== expv()) begin
                errs++;
                $display("FAIL idle_hold cyc %0d: got %h want %h", i, obs(), expv());
            end
        end
    endtask

    task automatic test_manual_advance();
        step(1, 0, 0);
        for (int i = 0; i < IC; i++) begin
            vecs++;
            if (obs() !== {16'h0001, 4'b1101, 2'd1, 1'b0}) begin
                errs++;
                $display("FAIL index_screen cyc %0d: got %h want %h", i, obs(), {16'h0001, 4'b1101, 2'd1, 1'b0});
            end
            step(0, 0, 0);
        end
        vecs++;
        if (obs() !== {16'hABCD, 4'b1101, 2'd1, 1'b0}) begin
            errs++;
            $display("FAIL index_to_show: got %h want %h", obs(), {16'hABCD, 4'b1101, 2'd1, 1'b0});
        end
    endtask

    task automatic test_wrap();
        logic [1:0] want;
        step(0, 0, 1);
        step(0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            want = 2'(k + 1);
            step(1, 0, 0);
            vecs++;
            if (page_idx !== want) begin
                errs++;
                $display("FAIL wrap_page %0d: got %0d want %0d", k, page_idx, want);
            end
            for (int i = 0; i < 9; i++) begin
                step(0, 0, 0);
                vecs++;
                if (obs() !== expv()) begin
                    errs++;
                    $display("FAIL wrap_model %0d/%0d: got %h want %h", k, i, obs(), expv());
                end
            end
        end
        vecs++;
        if (dp_in !== 4'b1110) begin
            errs++;
            $display("FAIL wrap_dp: got %b want 1110", dp_in);
        end
    endtask

    task automatic test_auto_rotate();
        int         cnt;
        int         want;
        logic [1:0] prev;
        step(0, 1, 0);
        for (int k = 0; k < 3; k++) begin
            want = (k == 0) ? AC : AC + IC;
            prev = page_idx;
            cnt  = 0;
            while (page_idx === prev && cnt < 60) begin
                step(0, 0, 0);
                cnt++;
                vecs++;
                if (obs() !== expv()) begin
                    errs++;
                    $display("FAIL auto_model: got %h want %h", obs(), expv());
                end
            end
            vecs++;
            if (cnt != want) begin
                errs++;
                $display("FAIL auto_period %0d: got %0d cycles want %0d", k, cnt, want);
            end
        end
        step(0, 1, 0);
        prev = page_idx;
        for (int i = 0; i < 40; i++) begin
            step(0, 0, 0);
            vecs++;
            if (page_idx !== prev || auto_mode !== 1'b0) begin
                errs++;
                $display("FAIL auto_stop cyc %0d: got page %0d auto %0d want page %0d auto 0", i, page_idx, auto_mode, prev);
            end
        end
    endtask

    task automatic test_coincident();
        int         cnt;
        logic [1:0] prev;
        logic [1:0] want;
        step(0, 1, 0);
        cnt = 0;
        while (!(!m_idx && m_age == AC - 1) && cnt < 60) begin
            step(0, 0, 0);
            cnt++;
        end
        vecs++;
        if (cnt >= 60) begin
            errs++;
            $display("FAIL coincide_wait: got timeout want expiry within 60");
        end
        prev = page_idx;
        want = prev + 2'd1;
        step(1, 0, 0);
        vecs++;
        if (page_idx !== want) begin
            errs++;
            $display("FAIL coincide_once: got %0d want %0d", page_idx, want);
        end
        step(0, 0, 0);
        want = want + 2'd1;
        step(1, 0, 0);
        for (int i = 0; i < IC; i++) begin
            vecs++;
            if ({hex3, hex2, hex1, hex0, page_idx} !== {14'd0, want, want}) begin
                errs++;
                $display("FAIL index_restart cyc %0d: got %h/%0d want %h/%0d", i,
                         {hex3, hex2, hex1, hex0}, page_idx, {14'd0, want}, want);
            end
            step(0, 0, 0);
        end
        vecs++;
        if ({hex3, hex2, hex1, hex0} !== PAGES_DEF[16*want +: 16]) begin
            errs++;
            $display("FAIL index_restart_end: got %h want %h", {hex3, hex2, hex1, hex0}, PAGES_DEF[16*want +: 16]);
        end
        step(0, 1, 0);
    endtask

    task automatic test_reset_mid_index();
        if (!m_auto) step(0, 1, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 1);
        vecs++;
        if (obs() !== {16'h0000, 4'b1110, 2'd0, 1'b0}) begin
            errs++;
            $display("FAIL reset_mid_index: got %h want %h", obs(), {16'h0000, 4'b1110, 2'd0, 1'b0});
        end
        step(0, 0, 0);
        vecs++;
        if (obs() !== {16'h1234, 4'b1110, 2'd0, 1'b0}) begin
            errs++;
            $display("FAIL reset_then_show: got %h want %h", obs(), {16'h1234, 4'b1110, 2'd0, 1'b0});
        end
    endtask

    task automatic test_random();
        bit nt, mt, rs;
        for (int i = 0; i < 1500; i++) begin
            pages_in = {$urandom, $urandom};
            nt = ($urandom_range(0, 19) == 0);
            mt = ($urandom_range(0, 39) == 0);
            rs = ($urandom_range(0, 299) == 0);
            step(nt, mt, rs);
            vecs++;
            if (obs() !== expv()) begin
                errs++;
                $display("FAIL random cyc %0d: got %h want %h", i, obs(), expv());
            end
        end
        pages_in = PAGES_DEF;
    endtask

    initial begin
        reset     = 1'b1;
        next_tick = 1'b0;
        mode_tick = 1'b0;
        pages_in  = PAGES_DEF;
        m_page = 0; m_auto = 0; m_idx = 0; m_age = 0; m_hex = 16'h0000;
        #2;
        test_reset();
        test_manual_advance();
        test_wrap();
        test_auto_rotate();
        test_coincident();
        test_reset_mid_index();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/disp_page_sched.md
Name: disp_page_sched

Overview:
- Scheduler that shares the single 4-digit seven-segment display (driven through disp_hex_mux) between four 16-bit data sources ("pages").
- Page selection is manual (debounced button tick) or automatic (rotating on a fixed period).
- On every page change, the page number is shown briefly before the page data appears.
- Sits between the debounce units and disp_hex_mux in board-level test tops.

Parameters:
- AUTO_CYCLES, 100_000_000, clk cycles per page in auto mode (2 s at 50 MHz); must be >= 2.
- INDEX_CYCLES, 25_000_000, clk cycles the page-number screen is held (0.5 s); must be >= 1.
- TW, 27, timer width; must satisfy 2^TW > max(AUTO_CYCLES, INDEX_CYCLES).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous active-high reset.
- next_tick, input, 1, one-cycle pulse from the debouncer; advance page.
- mode_tick, input, 1, one-cycle pulse; toggle auto/manual mode.
- pages_in, input, 64, page p = pages_in[16p+15:16p].
- hex3, output, 4, digit 3 nibble to disp_hex_mux.
- hex2, output, 4, digit 2 nibble.
- hex1, output, 4, digit 1 nibble.
- hex0, output, 4, digit 0 nibble.
- dp_in, output, 4, decimal points, active-low, to disp_hex_mux.
- page_idx, output, 2, current page.
- auto_mode, output, 1, 1 = auto rotation active.

Behaviour:
- Clocking: all state and outputs are registered; reset is synchronous and active-high. A reset asserted mid-operation wins over every other input in the same cycle.
- Reset values:
  - state = SHOW, page_idx = 0, auto_mode = 0, timer = 0.
  - hex3..hex0 = 0, dp_in = 4'b1110.
- States:
  - SHOW: outputs {hex3,hex2,hex1,hex0} = page[page_idx]. One-cycle latency from pages_in to the hex outputs; values are tracked continuously, not snapshotted.
  - INDEX: hex3..hex1 = 0, hex0 = {2'b00, page_idx} of the new page.
- Advance event (adv):
  - adv = next_tick OR (auto_mode AND state == SHOW AND timer == AUTO_CYCLES-1).
  - next_tick and timer expiry in the same cycle produce exactly one advance.
- On adv:
  - page_idx <= page_idx + 1, wrapping 3 -> 0.
  - state <= INDEX, timer <= 0.
- INDEX timing:
  - INDEX -> SHOW when timer == INDEX_CYCLES-1; timer <= 0 on that transition.
  - next_tick during INDEX advances again and restarts the INDEX hold.
- Auto timer:
  - The timer increments only in SHOW with auto_mode = 1, or in INDEX.
  - In SHOW with auto_mode = 0, the timer holds at 0.
- mode_tick:
  - auto_mode <= ~auto_mode; in SHOW, timer <= 0.
  - If coincident with next_tick, both take effect: the mode toggles and the page advances once.
  - mode_tick during INDEX does not alter the INDEX hold.
- Decimal points:
  - dp_in = ~(4'b0001 << page_idx), registered, updated in the same cycle as page_idx, in both states.
- Ticks wider than one cycle are treated as one tick per asserted cycle. Callers must supply pulses.

Decomposition:
- Shared header (disp_sched_defs.vh):
  - state encodings SHOW = 1'b0, INDEX = 1'b1;
  - NPAGE = 4;
  - default AUTO_CYCLES and INDEX_CYCLES.
- Sub-module cycle_timer (TW-bit counter with clear, enable and terminal-count compare against a runtime limit input).
  - It is instantiated once.
  - The FSM selects the limit (AUTO_CYCLES-1 or INDEX_CYCLES-1) by state.

Test Plan (AUTO_CYCLES=10, INDEX_CYCLES=3, pages 0..3 = 16'h1234, 16'hABCD, 16'h00FF, 16'hBEEF):
- Reset held 2 cycles, then released -> page_idx=0, auto_mode=0, dp_in=4'b1110; one cycle later hex3..0 = 1,2,3,4; no change over 50 idle cycles.
- Single next_tick -> next cycle page_idx=1, dp_in=4'b1101, hex={0,0,0,1} for exactly 3 cycles, then hex={A,B,C,D}.
- Four next_ticks spaced 10 cycles apart -> page_idx sequence 1,2,3,0 (wrap), dp_in returns to 4'b1110.
- mode_tick, then idle -> advance every 13 cycles (10 SHOW + 3 INDEX); second mode_tick stops rotation and page_idx holds.
- next_tick coincident with auto expiry -> page_idx increments by exactly 1. next_tick on cycle 2 of INDEX -> page increments again and INDEX restarts for a full 3 cycles.
- reset asserted during INDEX with auto_mode=1 -> next cycle state SHOW, page_idx=0, auto_mode=0, all outputs at reset values.
